// File: rtl/npc_pkg.sv
// Shared types and sizes for the npc core.
// Integer register file geometry lives here.
package npc_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] regidx_t;

    // True when an index names the hardwired zero register.
    function automatic logic is_x0(input regidx_t idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/regfile_wdec.sv
// One-hot write-select decoder for the register file.
// Gated by wen; bit 0 is never selected so x0 stays zero.
module regfile_wdec
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW
) (
    input  logic                     wen,
    input  logic [ADDR_WIDTH-1:0]    waddr,
    output logic [2**ADDR_WIDTH-1:0] wsel
);

    // Select exactly one destination when enabled, never x0.
    always_comb begin
        wsel = '0;
        if (wen) begin
            wsel[waddr] = 1'b1;
        end
        wsel[0] = 1'b0;
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: two async reads, one sync write.
// Define REGFILE_WRITE_BYPASS_EN to forward wdata to matching reads.
module register_file
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0]      wsel;
    logic [DATA_WIDTH-1:0] regs [DEPTH-1:1];
    logic                  unused_wsel0;

    regfile_wdec #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wdec (
        .wen  (wen),
        .waddr(waddr),
        .wsel (wsel)
    );

    // x0 has no storage, so its select line goes nowhere.
    assign unused_wsel0 = wsel[0];

    // Storage for x1..xN; async clear, per-register enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Read port 1: zero for x0, optional same-cycle forwarding.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = regs[raddr1];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wen && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end
`endif
        end
    end

    // Read port 2: zero for x0, optional same-cycle forwarding.
    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = regs[raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wen && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a queue scoreboard.
// Expected read data comes from a bench-side register model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];
    logic [31:0] exp_q [$];
    string       tag_q [$];

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic en);
        @(negedge clk);
        wen   = en;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (en && a != 0 && !reset) mdl[a] = d;
        wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a1,
                      input logic [4:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        #1;
        push({tag, "_p1"}, mdl[a1]);
        pop_chk(rdata1);
        push({tag, "_p2"}, mdl[a2]);
        pop_chk(rdata2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        reset  = 1'b1;
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        #1;
        push("por_p1", 32'h0);
        pop_chk(rdata1);
        push("por_p2", 32'h0);
        pop_chk(rdata2);
        @(negedge clk);
        reset = 1'b0;

        wr(5'd5, 32'h12345678, 1'b1);
        wr(5'd31, 32'hCAFEF00D, 1'b1);
        rd("pre_rst", 5'd5, 5'd31);

        // Mid-cycle async reset
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        #1;
        push("async_rst_x5", 32'h0);
        pop_chk(rdata1);
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            push($sformatf("rst_x%0d", i), 32'h0);
            pop_chk(rdata1);
        end
        @(negedge clk);
        reset = 1'b0;

        wr(5'd3, 32'hDEADBEEF, 1'b1);
        rd("basic_x3", 5'd3, 5'd3);

        // x0 protection, including during the write cycle
        @(negedge clk);
        wen    = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        #1;
        push("x0_during", 32'h0);
        pop_chk(rdata1);
        @(posedge clk);
        #1;
        wen = 1'b0;
        rd("x0_after", 5'd0, 5'd0);

        wr(5'd7, 32'h11, 1'b1);
        wr(5'd7, 32'h22, 1'b0);
        rd("wen_gate", 5'd7, 5'd3);

        wr(5'd1, 32'hA, 1'b1);
        wr(5'd2, 32'hB, 1'b1);
        rd("dual", 5'd1, 5'd2);

        // Read during write of x1
        @(negedge clk);
        raddr1 = 5'd1;
        raddr2 = 5'd2;
        wen    = 1'b1;
        waddr  = 5'd1;
        wdata  = 32'hC;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        push("rdw_before", 32'hC);
`else
        push("rdw_before", 32'hA);
`endif
        pop_chk(rdata1);
        push("rdw_other", 32'hB);
        pop_chk(rdata2);
        @(posedge clk);
        #1;
        mdl[1] = 32'hC;
        wen = 1'b0;
        rd("rdw_after", 5'd1, 5'd1);

        // Reset wins over a write on the same edge
        wr(5'd9, 32'h99, 1'b1);
        rd("x9_pre", 5'd9, 5'd9);
        @(negedge clk);
        reset = 1'b1;
        wen   = 1'b1;
        waddr = 5'd9;
        wdata = 32'h55;
        @(posedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        wen   = 1'b0;
        rd("collide_x9", 5'd9, 5'd1);

        // Scattered writes, independent port reads
        for (int i = 0; i < 12; i++) begin
            wr(5'($urandom_range(0, 31)), $urandom, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            rd("rand", 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
